// File: rtl/imem_arb.sv
// Two-master arbiter in front of a combinational instruction-memory read port.
// Define IMEM_ARB_RR_EN for round-robin with burst limiting; default is fixed priority (m0 first).
module imem_arb #(
  parameter int DEPTH     = 32,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] imem_iaddr,
  input  logic [31:0] imem_idata
);

  localparam int          CW      = $clog2(BURST_MAX + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [CW-1:0] BMAX_W = CW'(BURST_MAX);
  localparam logic [CW-1:0] ONE_W  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          last_r, last_nxt_s;   // 1: m1 was the last owner
  logic          sel0_s, sel1_s;
  logic          m0_gnt_s, m1_gnt_s;
  logic [31:0]   iaddr_s;
  logic          m0_rvalid_r, m1_rvalid_r, m0_err_r, m1_err_r;
  logic [31:0]   m0_rdata_r, m1_rdata_r;

  function automatic logic addr_illegal(input logic [31:0] addr);
    addr_illegal = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= DEPTH_W);
  endfunction

  // State, burst counter and last-owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Arbitration decision and next-state computation; no grant while held in reset
  always_comb begin
    sel0_s = 1'b0;
    sel1_s = 1'b0;
    if (!rst_n) begin
      sel0_s = 1'b0;
      sel1_s = 1'b0;
    end else begin
`ifdef IMEM_ARB_RR_EN
      case (state_r)
        IDLE: begin
          if (m0_req && m1_req) begin
            sel0_s = last_r;
            sel1_s = ~last_r;
          end else begin
            sel0_s = m0_req;
            sel1_s = m1_req;
          end
        end
        OWN0: begin
          if (m0_req) begin
            sel1_s = m1_req && (cnt_r == BMAX_W);
            sel0_s = ~sel1_s;
          end else begin
            sel1_s = m1_req;
          end
        end
        OWN1: begin
          if (m1_req) begin
            sel0_s = m0_req && (cnt_r == BMAX_W);
            sel1_s = ~sel0_s;
          end else begin
            sel0_s = m0_req;
          end
        end
        default: begin
          sel0_s = 1'b0;
          sel1_s = 1'b0;
        end
      endcase
`else
      sel0_s = m0_req;
      sel1_s = m1_req & ~m0_req;
`endif
    end

    if (sel0_s) begin
      state_nxt_s = OWN0;
      last_nxt_s  = 1'b0;
    end else if (sel1_s) begin
      state_nxt_s = OWN1;
      last_nxt_s  = 1'b1;
    end else begin
      state_nxt_s = IDLE;
      last_nxt_s  = last_r;
    end

`ifdef IMEM_ARB_RR_EN
    // A grant that keeps the same owner extends the burst; any switch restarts it at one
    if ((sel0_s && state_r == OWN0) || (sel1_s && state_r == OWN1)) begin
      cnt_nxt_s = (cnt_r == BMAX_W) ? cnt_r : cnt_r + ONE_W;
    end else if (sel0_s || sel1_s) begin
      cnt_nxt_s = ONE_W;
    end else begin
      cnt_nxt_s = {CW{1'b0}};
    end
`else
    cnt_nxt_s = cnt_r;
`endif
  end

  // Grant and memory-address outputs
  always_comb begin
    m0_gnt_s = sel0_s;
    m1_gnt_s = sel1_s;
    if (sel0_s) begin
      iaddr_s = m0_addr;
    end else if (sel1_s) begin
      iaddr_s = m1_addr;
    end else begin
      iaddr_s = 32'h0000_0000;
    end
  end

  // Response registers: one-cycle strobe, data held between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_r <= 1'b0;
      m0_err_r    <= 1'b0;
      m0_rdata_r  <= 32'h0000_0000;
      m1_rvalid_r <= 1'b0;
      m1_err_r    <= 1'b0;
      m1_rdata_r  <= 32'h0000_0000;
    end else begin
      m0_rvalid_r <= m0_gnt_s;
      m0_err_r    <= m0_gnt_s & addr_illegal(m0_addr);
      m1_rvalid_r <= m1_gnt_s;
      m1_err_r    <= m1_gnt_s & addr_illegal(m1_addr);
      if (m0_gnt_s) begin
        m0_rdata_r <= addr_illegal(m0_addr) ? 32'h0000_0000 : imem_idata;
      end else begin
        m0_rdata_r <= m0_rdata_r;
      end
      if (m1_gnt_s) begin
        m1_rdata_r <= addr_illegal(m1_addr) ? 32'h0000_0000 : imem_idata;
      end else begin
        m1_rdata_r <= m1_rdata_r;
      end
    end
  end

  assign m0_gnt     = m0_gnt_s;
  assign m1_gnt     = m1_gnt_s;
  assign imem_iaddr = iaddr_s;
  assign m0_rvalid  = m0_rvalid_r;
  assign m0_err     = m0_err_r;
  assign m0_rdata   = m0_rdata_r;
  assign m1_rvalid  = m1_rvalid_r;
  assign m1_err     = m1_err_r;
  assign m1_rdata   = m1_rdata_r;

endmodule

// File: tb/tb_imem_arb.sv
// Scoreboard bench for imem_arb: directed stimulus pushes expected responses, a monitor pops and compares.
module tb_imem_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_rdata, m1_rdata, imem_iaddr, imem_idata;
  logic        m0_rvalid, m1_rvalid, m0_err, m1_err;

  int total = 0;
  int bad   = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;

  imem_arb #(.DEPTH(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .imem_iaddr(imem_iaddr), .imem_idata(imem_idata)
  );

  always #5 clk = ~clk;

  // word i holds 0x1000_0000 + i; beyond the array the memory returns garbage
  assign imem_idata = (imem_iaddr[31:2] < 30'd32) ? (32'h1000_0000 + {2'b00, imem_iaddr[31:2]})
                                                  : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_port(input int p, input logic rv, input logic er, input logic [31:0] rd);
    logic [32:0] e;
    logic        exp_v;
    exp_v = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("m%0d_rvalid", p), {31'd0, rv}, {31'd0, exp_v});
    if (exp_v) begin
      if (p == 0) begin
        e = q0.pop_front();
        last0 = e[31:0];
      end else begin
        e = q1.pop_front();
        last1 = e[31:0];
      end
      chk($sformatf("m%0d_err", p), {31'd0, er}, {31'd0, e[32]});
      chk($sformatf("m%0d_rdata", p), rd, e[31:0]);
    end else begin
      chk($sformatf("m%0d_err_idle", p), {31'd0, er}, 32'd0);
      chk($sformatf("m%0d_rdata_hold", p), rd, (p == 0) ? last0 : last1);
    end
  endtask

  // Monitor: samples responses 1 time unit after every rising edge
  always @(posedge clk) begin
    #1;
    mon_port(0, m0_rvalid, m0_err, m0_rdata);
    mon_port(1, m1_rvalid, m1_err, m1_rdata);
  end

  // One bus cycle: drive, check grants mid-cycle, record expected response
  task automatic cyc(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                     input logic eg0, input logic eg1, input logic [31:0] ed, input logic ee);
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
    @(negedge clk);
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg1});
    chk("imem_iaddr", imem_iaddr, eg0 ? a0 : (eg1 ? a1 : 32'h0));
    if (eg0) q0.push_back({ee, ed});
    if (eg1) q1.push_back({ee, ed});
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_iaddr", imem_iaddr, 32'h0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = 32'h0; m1_addr = 32'h0;
    #3;
    chk_reset_outputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // m0 alone, back-to-back words 0..2, granted on the first edge out of reset
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0000, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0001, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0002, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // m1 illegal addresses and the last legal word
    cyc(1'b0, 32'h0, 1'b1, 32'h82, 1'b0, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h7E, 1'b0, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h7C, 1'b0, 1'b1, 32'h1000_001F, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef IMEM_ARB_RR_EN
    // both held: m0 x4, m1 x4, m0 again, no bubble at switches
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'(4 * i), 1'b1, 32'(32'h40 + 4 * i), 1'b1, 1'b0, 32'(32'h1000_0000 + i), 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h10, 1'b1, 32'(32'h40 + 4 * i), 1'b0, 1'b1, 32'(32'h1000_0010 + i), 1'b0);
    cyc(1'b1, 32'h10, 1'b1, 32'h50, 1'b1, 1'b0, 32'h1000_0004, 1'b0);
    // owner drops req: m1 granted in the same cycle
    cyc(1'b0, 32'h10, 1'b1, 32'h50, 1'b0, 1'b1, 32'h1000_0014, 1'b0);
`else
    // fixed priority: m0 always wins while requesting
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'(4 * i), 1'b1, 32'h40, 1'b1, 1'b0, 32'(32'h1000_0000 + i), 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h1000_0010, 1'b0);
    cyc(1'b1, 32'h8, 1'b1, 32'h44, 1'b1, 1'b0, 32'h1000_0002, 1'b0);
`endif
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // reset lands in an m0 grant cycle: transaction dropped
    m0_req = 1'b1; m0_addr = 32'h10; m1_req = 1'b0;
    #1;
    chk("pre_rst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    last0 = 32'h0;
    last1 = 32'h0;
    #1;
    chk_reset_outputs();
    m0_req = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    // first tie after reset goes to m0
    cyc(1'b1, 32'h20, 1'b1, 32'h24, 1'b1, 1'b0, 32'h1000_0008, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
